// File: rtl/vehicle_sensor_frontend.sv
// Purpose: condition the entry/exit loop sensors into clean levels, arrive/depart pulses and stuck faults.
// Latency: DEBOUNCE_CYCLES+2 clk edges from a stable raw change to the clean level and its pulse.
// Backpressure: none; free-running conditioning, outputs are levels and single-cycle pulses.

// One sensor channel: 2-flop synchroniser, hold-time debounce FSM and stuck-high monitor.
module vehicle_sensor_channel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_clean,
    output logic o_arrive,
    output logic o_depart,
    output logic o_fault
);

    localparam int SC_W = (STUCK_CYCLES < 2) ? 1 : $clog2(STUCK_CYCLES + 1);
    localparam logic [15:0]     DC_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STUCK_CYCLES);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_PEND = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_PEND = 2'd3
    } state_t;

    logic            r_sync1;
    logic            r_s;
    state_t          r_state;
    logic [15:0]     r_dc;
    logic [SC_W-1:0] r_sc;
    logic            r_clean;
    logic            r_arrive;
    logic            r_depart;

    state_t          w_state_nxt;
    logic [15:0]     w_dc_nxt;
    logic [SC_W-1:0] w_sc_nxt;
    logic [SC_W-1:0] w_sc_inc;
    logic            w_clean_nxt;
    logic            w_arrive_nxt;
    logic            w_depart_nxt;

    // Bring the asynchronous loop input into the clk domain; only r_s feeds the filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_s     <= r_sync1;
        end
    end

    // Stuck counter advance, holding once the fault threshold is reached.
    always_comb begin
        w_sc_inc = (r_sc == SC_MAX) ? r_sc : (r_sc + SC_W'(1));
    end

    // Debounce FSM next state: a level change needs DEBOUNCE_CYCLES identical samples in a row.
    always_comb begin
        w_state_nxt  = r_state;
        w_dc_nxt     = r_dc;
        w_sc_nxt     = r_sc;
        w_clean_nxt  = r_clean;
        w_arrive_nxt = 1'b0;
        w_depart_nxt = 1'b0;
        case (r_state)
            ST_LOW: begin
                w_clean_nxt = 1'b0;
                w_dc_nxt    = 16'd0;
                if (r_s) begin
                    w_state_nxt = ST_RISE_PEND;
                    w_dc_nxt    = 16'd1;
                end
            end
            ST_RISE_PEND: begin
                w_clean_nxt = 1'b0;
                if (!r_s) begin
                    w_state_nxt = ST_LOW;
                    w_dc_nxt    = 16'd0;
                end else if (r_dc == DC_LAST) begin
                    w_state_nxt  = ST_HIGH;
                    w_dc_nxt     = 16'd0;
                    w_clean_nxt  = 1'b1;
                    w_arrive_nxt = 1'b1;
                    w_sc_nxt     = '0;
                end else begin
                    w_dc_nxt = r_dc + 16'd1;
                end
            end
            ST_HIGH: begin
                w_clean_nxt = 1'b1;
                w_dc_nxt    = 16'd0;
                w_sc_nxt    = w_sc_inc;
                if (!r_s) begin
                    w_state_nxt = ST_FALL_PEND;
                    w_dc_nxt    = 16'd1;
                end
            end
            ST_FALL_PEND: begin
                // The vehicle is still considered present, so the stuck count keeps running.
                w_clean_nxt = 1'b1;
                w_sc_nxt    = w_sc_inc;
                if (r_s) begin
                    w_state_nxt = ST_HIGH;
                    w_dc_nxt    = 16'd0;
                end else if (r_dc == DC_LAST) begin
                    w_state_nxt  = ST_LOW;
                    w_dc_nxt     = 16'd0;
                    w_clean_nxt  = 1'b0;
                    w_depart_nxt = 1'b1;
                    w_sc_nxt     = '0;
                end else begin
                    w_dc_nxt = r_dc + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_dc_nxt    = 16'd0;
                w_sc_nxt    = '0;
                w_clean_nxt = 1'b0;
            end
        endcase
    end

    // FSM, counters and registered outputs; reset drops everything immediately with no pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_LOW;
            r_dc     <= 16'd0;
            r_sc     <= '0;
            r_clean  <= 1'b0;
            r_arrive <= 1'b0;
            r_depart <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dc     <= w_dc_nxt;
            r_sc     <= w_sc_nxt;
            r_clean  <= w_clean_nxt;
            r_arrive <= w_arrive_nxt;
            r_depart <= w_depart_nxt;
        end
    end

    assign o_clean  = r_clean;
    assign o_arrive = r_arrive;
    assign o_depart = r_depart;
    assign o_fault  = (r_sc == SC_MAX);

endmodule

// Top: two independent channels; arbitration between entry and exit is left to the controller.
module vehicle_sensor_frontend #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw_entry,
    input  logic i_raw_exit,
    output logic o_sensor_entry,
    output logic o_sensor_exit,
    output logic o_entry_arrive,
    output logic o_entry_depart,
    output logic o_exit_arrive,
    output logic o_exit_depart,
    output logic o_fault_entry,
    output logic o_fault_exit
);

    vehicle_sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_entry (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (i_raw_entry),
        .o_clean  (o_sensor_entry),
        .o_arrive (o_entry_arrive),
        .o_depart (o_entry_depart),
        .o_fault  (o_fault_entry)
    );

    vehicle_sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_exit (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (i_raw_exit),
        .o_clean  (o_sensor_exit),
        .o_arrive (o_exit_arrive),
        .o_depart (o_exit_depart),
        .o_fault  (o_fault_exit)
    );

endmodule

// File: tb/tb_vehicle_sensor_frontend.sv
// Bench for vehicle_sensor_frontend with DEBOUNCE_CYCLES=4 and STUCK_CYCLES=20.
// A run-length reference model predicts every output after each edge.
// Directed steps follow the test plan, then a randomized toggle segment.
module tb_vehicle_sensor_frontend;

    localparam int DEB = 4;
    localparam int STK = 20;

    logic clk;
    logic reset;
    logic raw_entry;
    logic raw_exit;
    logic sensor_entry, sensor_exit;
    logic entry_arrive, entry_depart, exit_arrive, exit_depart;
    logic fault_entry, fault_exit;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = entry, 1 = exit.
    int m_sy1   [2];
    int m_s     [2];
    int m_run   [2];
    int m_clean [2];
    int m_rise  [2];
    int m_arr   [2];
    int m_dep   [2];
    int m_edge;

    vehicle_sensor_frontend #(
        .DEBOUNCE_CYCLES (DEB),
        .STUCK_CYCLES    (STK)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_raw_entry    (raw_entry),
        .i_raw_exit     (raw_exit),
        .o_sensor_entry (sensor_entry),
        .o_sensor_exit  (sensor_exit),
        .o_entry_arrive (entry_arrive),
        .o_entry_depart (entry_depart),
        .o_exit_arrive  (exit_arrive),
        .o_exit_depart  (exit_depart),
        .o_fault_entry  (fault_entry),
        .o_fault_exit   (fault_exit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_sy1[c] = 0; m_s[c] = 0; m_run[c] = 0; m_clean[c] = 0;
            m_rise[c] = 0; m_arr[c] = 0; m_dep[c] = 0;
        end
    endtask

    function automatic logic exp_fault(input int c);
        return (m_clean[c] == 1) && ((m_edge - m_rise[c]) >= STK);
    endfunction

    task automatic check_all();
        chk("sensor_entry", sensor_entry, logic'(m_clean[0]));
        chk("sensor_exit",  sensor_exit,  logic'(m_clean[1]));
        chk("entry_arrive", entry_arrive, logic'(m_arr[0]));
        chk("entry_depart", entry_depart, logic'(m_dep[0]));
        chk("exit_arrive",  exit_arrive,  logic'(m_arr[1]));
        chk("exit_depart",  exit_depart,  logic'(m_dep[1]));
        chk("fault_entry",  fault_entry,  exp_fault(0));
        chk("fault_exit",   fault_exit,   exp_fault(1));
    endtask

    // One clock edge: advance the model with the pre-edge values, then compare 1 time unit later.
    // Clean flips once DEB consecutive synchronised samples disagree with it.
    task automatic tick();
        int rv;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            m_edge++;
            for (int c = 0; c < 2; c++) begin
                rv = (c == 0) ? int'(raw_entry) : int'(raw_exit);
                m_arr[c] = 0;
                m_dep[c] = 0;
                if (m_s[c] != m_clean[c]) m_run[c]++;
                else                      m_run[c] = 0;
                if (m_run[c] == DEB) begin
                    m_run[c]   = 0;
                    m_clean[c] = 1 - m_clean[c];
                    if (m_clean[c] == 1) begin
                        m_arr[c]  = 1;
                        m_rise[c] = m_edge;
                    end else begin
                        m_dep[c] = 1;
                    end
                end
                m_s[c]   = m_sy1[c];
                m_sy1[c] = rv;
            end
        end
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int pat [8] = '{1, 1, 1, 0, 1, 1, 0, 1};
        m_edge    = 0;
        reset     = 1'b1;
        raw_entry = 1'b0;
        raw_exit  = 1'b0;
        model_reset();

        // Reset state.
        tick();
        chk("reset_sensor_entry", sensor_entry, 1'b0);
        reset = 1'b0;
        ticks(3);

        // Clean rise and fall on entry.
        raw_entry = 1'b1;
        ticks(5);
        chk("t1_no_early_rise", sensor_entry, 1'b0);
        tick();
        chk("t1_rise_edge6", sensor_entry, 1'b1);
        chk("t1_arrive", entry_arrive, 1'b1);
        tick();
        chk("t1_arrive_one_cycle", entry_arrive, 1'b0);
        ticks(13);
        raw_entry = 1'b0;
        ticks(5);
        chk("t1_no_early_fall", sensor_entry, 1'b1);
        tick();
        chk("t1_fall_edge6", sensor_entry, 1'b0);
        chk("t1_depart", entry_depart, 1'b1);
        chk("t1_exit_quiet", sensor_exit, 1'b0);
        ticks(8);

        // Bounce rejection on exit.
        for (int i = 0; i < 8; i++) begin
            raw_exit = logic'(pat[i]);
            tick();
            chk("t2_no_change", sensor_exit, 1'b0);
        end
        raw_exit = 1'b1;
        ticks(4);
        chk("t2_still_low", sensor_exit, 1'b0);
        tick();
        chk("t2_rise", sensor_exit, 1'b1);
        chk("t2_arrive", exit_arrive, 1'b1);
        raw_exit = 1'b0;
        ticks(10);

        // Fall-side bounce on entry.
        raw_entry = 1'b1;
        ticks(10);
        raw_entry = 1'b0;
        ticks(3);
        raw_entry = 1'b1;
        tick();
        raw_entry = 1'b0;
        ticks(5);
        chk("t3_no_premature_fall", sensor_entry, 1'b1);
        chk("t3_no_early_depart", entry_depart, 1'b0);
        tick();
        chk("t3_fall", sensor_entry, 1'b0);
        chk("t3_depart", entry_depart, 1'b1);
        ticks(8);

        // Stuck fault on entry, then asynchronous reset while faulted.
        raw_entry = 1'b1;
        ticks(25);
        chk("t4_fault_not_yet", fault_entry, 1'b0);
        tick();
        chk("t4_fault_edge20", fault_entry, 1'b1);
        chk("t4_sensor_held", sensor_entry, 1'b1);
        ticks(4);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t6_async_sensor", sensor_entry, 1'b0);
        chk("t6_async_fault", fault_entry, 1'b0);
        check_all();
        tick();
        reset = 1'b0;
        ticks(5);
        chk("t6_full_debounce", sensor_entry, 1'b0);
        tick();
        chk("t6_rise_after_reset", sensor_entry, 1'b1);
        ticks(24);
        chk("t4_fault_again", fault_entry, 1'b1);
        raw_entry = 1'b0;
        ticks(5);
        chk("t4_fault_before_fall", fault_entry, 1'b1);
        tick();
        chk("t4_fault_clears", fault_entry, 1'b0);
        chk("t4_sensor_falls", sensor_entry, 1'b0);
        ticks(6);

        // Simultaneous channels.
        raw_entry = 1'b1;
        raw_exit  = 1'b1;
        ticks(6);
        chk("t5_entry_arrive", entry_arrive, 1'b1);
        chk("t5_exit_arrive", exit_arrive, 1'b1);
        raw_entry = 1'b0;
        raw_exit  = 1'b0;
        ticks(10);

        // Randomized toggling on both channels against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) raw_entry = ~raw_entry;
            if ($urandom_range(0, 5) == 0) raw_exit  = ~raw_exit;
            if ($urandom_range(0, 199) == 0) begin
                raw_entry = 1'b1;
                raw_exit  = 1'b1;
                ticks(30);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vehicle_sensor_frontend.md
# vehicle_sensor_frontend

Conditions the two raw vehicle-presence sensors (entry loop, exit loop) before they reach the parking controller FSM. Each channel is synchronised, debounced with a hold-time filter and monitored for a stuck-high condition. The block drives clean `sensor_entry`/`sensor_exit` levels plus one-cycle arrive/depart pulses for logging and counting. It sits directly upstream of the parking controller, between the sensor pins and the controller's sensor inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronised samples required to change a clean output. Legal range is 2..65535.
- `STUCK_CYCLES`, default 1000000: consecutive cycles of clean-high after which the fault flag asserts. Must be ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `raw_entry`  in  1  raw entry-loop sensor; asynchronous, may bounce.
- `raw_exit`  in  1  raw exit-loop sensor; asynchronous, may bounce.
- `sensor_entry`  out  1  clean entry presence level, feeds the controller.
- `sensor_exit`  out  1  clean exit presence level, feeds the controller.
- `entry_arrive`  out  1  one-cycle pulse when `sensor_entry` rises.
- `entry_depart`  out  1  one-cycle pulse when `sensor_entry` falls.
- `exit_arrive`  out  1  one-cycle pulse when `sensor_exit` rises.
- `exit_depart`  out  1  one-cycle pulse when `sensor_exit` falls.
- `fault_entry`  out  1  entry sensor held present ≥ `STUCK_CYCLES`.
- `fault_exit`  out  1  exit sensor held present ≥ `STUCK_CYCLES`.

## Operation
- Two identical, fully independent channels (entry, exit). There is no cross-channel interlock; arbitration between simultaneous entry and exit belongs to the controller.
- Each raw input passes through a 2-flop synchroniser (reset to 0). All filter logic uses only the second flop, `s`.
- Per-channel FSM uses a debounce counter `dc` (16 bit) and a stuck counter `sc` (wide enough for `STUCK_CYCLES`, saturating).
  - LOW: clean=0, `dc`=0. If `s`=1, go to RISE_PEND with `dc`=1.
  - RISE_PEND: clean=0. If `s`=0, go to LOW. If `s`=1 and `dc`=`DEBOUNCE_CYCLES`−1, go to HIGH, set clean=1, pulse arrive, set `sc`=0. Otherwise `dc`+1.
  - HIGH: clean=1, `dc`=0. `sc` increments each cycle and saturates at `STUCK_CYCLES`. If `s`=0, go to FALL_PEND with `dc`=1.
  - FALL_PEND: clean=1. If `s`=1, return to HIGH without resetting `sc`. If `s`=0 and `dc`=`DEBOUNCE_CYCLES`−1, go to LOW, set clean=0, pulse depart, set `sc`=0. Otherwise `dc`+1. `sc` keeps counting in this state.
- Fault output is 1 exactly when `sc` = `STUCK_CYCLES`.
  - Clean output stays 1 while faulted, because the vehicle is treated as possibly present.
  - The fault clears on the same edge that clean falls.
  - The fault never alters the pulses.
- Arrive and depart pulses for a channel are mutually exclusive and cannot occur on consecutive cycles. Each arrive is followed by exactly one depart before the next arrive.
- Unused state encodings recover to LOW with clean=0 on the next edge.

## Timing
- Reset (async assert): all outputs 0, synchronisers 0, both FSMs LOW, all counters 0. Effect is immediate, not on the next edge.
- Reset deassert: the first sample is taken on the next `clk` edge.
- Mid-operation reset: `sensor_*` drops at once with no depart pulse. The downstream controller is reset by the same signal.
- Latency, rise: `raw` stable 1 starting before edge 1 → `sensor_*` and arrive are high after edge `DEBOUNCE_CYCLES`+2. Fall latency is symmetric.
- Glitch rejection:
  - Any `raw` pulse shorter than `DEBOUNCE_CYCLES` cycles, after synchronisation, never changes clean.
  - A bounce during FALL_PEND restarts the fall debounce.
- Pulse timing: pulses are registered and one cycle wide, aligned with the clean-level change.
- Both channels may pulse on the same cycle.
- Fault timing: the fault asserts `STUCK_CYCLES` edges after clean rose, provided clean has not fallen in between.

## Test plan
- **Clean rise and fall.** Use `DEBOUNCE_CYCLES`=4. Raise `raw_entry` cleanly for 20 cycles, then lower it.
  - `sensor_entry` rises after edge 6 and falls 6 edges after `raw` falls.
  - One `entry_arrive` and one `entry_depart` pulse, each 1 cycle.
  - `sensor_exit` and its pulses stay 0.
- **Bounce rejection.** Use `DEBOUNCE_CYCLES`=4. Drive `raw_exit` in the pattern 1,1,1,0,1,1,0,1 (cycles), then hold 1.
  - No output change during the pattern.
  - `sensor_exit` rises 6 edges after the final stable rise, with a single `exit_arrive`.
- **Fall-side bounce.** While `sensor_entry`=1, drive `raw_entry` 0 for 3 cycles, then 1, then 0 held.
  - No premature fall.
  - Exactly one `entry_depart`, 6 edges after the final fall.
- **Stuck fault.** Use `STUCK_CYCLES`=20 and hold `raw_entry`=1.
  - `fault_entry` asserts exactly 20 edges after `sensor_entry` rose, and `sensor_entry` stays 1.
  - Releasing `raw_entry` clears `fault_entry` on the same edge `sensor_entry` falls.
- **Simultaneous channels.** Raise `raw_entry` and `raw_exit` on the same cycle.
  - Both clean outputs rise on the same edge, and `entry_arrive` and `exit_arrive` are both high that cycle.
- **Reset mid-operation.** Assert `reset` asynchronously (between clock edges) while `sensor_entry`=1 and `fault_entry`=1.
  - All outputs go to 0 before the next clock edge.
  - After release with `raw_entry` still 1, a full 6-edge debounce is required before `sensor_entry` returns high.
